// File: rtl/leddc_pkg.sv
// Shared constants and types for the LED display controller data path.
// The gap defaults are shared with the controller so its word/frame edge detection agrees with the serializer.
package leddc_pkg;

    localparam int PIX_W             = 16;
    localparam int PIX_PER_FRAME     = 512;
    localparam int PIX_IDX_W         = 9;
    localparam int DEF_GAP_CYC       = 2;
    localparam int DEF_FRAME_GAP_CYC = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_FGAP  = 2'd3
    } ser_state_t;

    // Counter width able to hold every value up to and including max_gap.
    function automatic int gap_cnt_width(input int max_gap);
        return $clog2(max_gap + 1);
    endfunction

endpackage

// File: rtl/leddc_sync_fifo.sv
// Small circular-buffer FIFO with combinational head read, so the consumer
// can use the head word on the same edge that pops it.
module leddc_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             wr_en;
    logic             rd_en;

    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign pop_data = mem[rd_ptr_reg];

    // A full FIFO drops the write; there is no bypass path.
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/leddc_pixel_serializer.sv
// Buffers 16-bit pixel words and shifts them LSB first onto the DAI/DEN link,
// inserting DEN-low gaps between words and a longer gap after each frame.
module leddc_pixel_serializer #(
    parameter int DEPTH         = 4,
    parameter int PIX_PER_FRAME = leddc_pkg::PIX_PER_FRAME,
    parameter int GAP_CYC       = leddc_pkg::DEF_GAP_CYC,
    parameter int FRAME_GAP_CYC = leddc_pkg::DEF_FRAME_GAP_CYC
) (
    input  logic                           DCK,
    input  logic                           rst,
    input  logic                           pix_valid,
    input  logic [leddc_pkg::PIX_W-1:0]    pix_data,
    output logic                           pix_ready,
    output logic                           DAI,
    output logic                           DEN,
    output logic [leddc_pkg::PIX_IDX_W-1:0] pix_idx,
    output logic                           frame_done,
    output logic                           busy
);

    import leddc_pkg::*;

    localparam int GAP_W = gap_cnt_width(FRAME_GAP_CYC);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    ser_state_t             state_reg;
    ser_state_t             state_next;
    logic [PIX_W-1:0]       shreg_reg;
    logic [PIX_W-1:0]       shreg_next;
    logic [3:0]             bit_cnt_reg;
    logic [3:0]             bit_cnt_next;
    logic [GAP_W-1:0]       gap_cnt_reg;
    logic [GAP_W-1:0]       gap_cnt_next;
    logic [PIX_IDX_W-1:0]   pix_idx_reg;
    logic [PIX_IDX_W-1:0]   pix_idx_next;
    logic                   den_reg;
    logic                   den_next;
    logic                   dai_reg;
    logic                   dai_next;
    logic                   frame_done_reg;
    logic                   frame_done_next;

    logic                   fifo_pop;
    logic [PIX_W-1:0]       fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;

    logic                   last_bit;
    logic                   last_pix;
    logic                   gap_done;
    logic                   fgap_done;

    leddc_sync_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (DCK),
        .srst      (rst),
        .push      (pix_valid),
        .push_data (pix_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign last_bit = (bit_cnt_reg == 4'd15);
    assign last_pix = (pix_idx_reg == PIX_IDX_W'(PIX_PER_FRAME - 1));

    // The IDLE cycle that follows a gap is itself DEN-low, so the gap states
    // leave one count early; the link then sees exactly GAP_CYC / FRAME_GAP_CYC
    // low cycles whenever the next word is already waiting.
    assign gap_done  = (gap_cnt_reg == GAP_W'(GAP_CYC - 1));
    assign fgap_done = (gap_cnt_reg == GAP_W'(FRAME_GAP_CYC - 1));

    always_ff @(posedge DCK) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            shreg_reg      <= '0;
            bit_cnt_reg    <= '0;
            gap_cnt_reg    <= '0;
            pix_idx_reg    <= '0;
            den_reg        <= 1'b0;
            dai_reg        <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shreg_reg      <= shreg_next;
            bit_cnt_reg    <= bit_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            pix_idx_reg    <= pix_idx_next;
            den_reg        <= den_next;
            dai_reg        <= dai_next;
            frame_done_reg <= frame_done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    state_next = last_pix ? ST_FGAP : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    state_next = ST_IDLE;
                end
            end
            ST_FGAP: begin
                if (fgap_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        shreg_next      = shreg_reg;
        bit_cnt_next    = bit_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        pix_idx_next    = pix_idx_reg;
        den_next        = 1'b0;
        dai_next        = 1'b0;
        frame_done_next = 1'b0;
        fifo_pop        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    shreg_next   = fifo_head;
                    bit_cnt_next = '0;
                    den_next     = 1'b1;
                    dai_next     = fifo_head[0];
                end
            end
            ST_SHIFT: begin
                shreg_next   = shreg_reg >> 1;
                bit_cnt_next = bit_cnt_reg + 4'd1;
                if (last_bit) begin
                    gap_cnt_next    = GAP_W'(1);
                    frame_done_next = last_pix;
                end else begin
                    den_next = 1'b1;
                    dai_next = shreg_reg[1];
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    pix_idx_next = pix_idx_reg + PIX_IDX_W'(1);
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                end
            end
            ST_FGAP: begin
                if (fgap_done) begin
                    pix_idx_next = '0;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                end
            end
            default: begin
                den_next = 1'b0;
            end
        endcase
    end

    assign pix_ready  = !fifo_full;
    assign DEN        = den_reg;
    assign DAI        = dai_reg;
    assign pix_idx    = pix_idx_reg;
    assign frame_done = frame_done_reg;
    assign busy       = (state_reg != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_leddc_pixel_serializer.sv
// Directed bench for the pixel serializer: a negedge monitor rebuilds words
// from DAI/DEN and compares them against a queue filled on each accepted push.
module tb_leddc_pixel_serializer;

    import leddc_pkg::*;

    logic        DCK = 1'b0;
    logic        rst;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_ready;
    logic        DAI;
    logic        DEN;
    logic [8:0]  pix_idx;
    logic        frame_done;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] exp_q [$];
    int          rise_q [$];

    // monitor state
    logic        den_prev = 1'b0;
    logic        mon_first = 1'b1;
    logic [15:0] mon_word = '0;
    int          bitpos = 0;
    int          out_cnt = 0;
    int          low_len = 0;
    int          started = 0;
    int          fd_cycles = 0;
    int          frame_gap_len = 0;
    int          acc_cyc = 0;

    leddc_pixel_serializer dut (
        .DCK        (DCK),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .DAI        (DAI),
        .DEN        (DEN),
        .pix_idx    (pix_idx),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial forever #5 DCK = ~DCK;

    always @(posedge DCK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    // Called at posedge+2; returns at posedge+2 right after the accepting edge.
    task automatic push_word(input logic [15:0] d);
        int  n;
        logic rdy;
        n = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        forever begin
            rdy = pix_ready;
            @(posedge DCK);
            #2;
            if (rdy) break;
            n++;
            if (n > 5000) begin
                fail_now("push_timeout");
                break;
            end
        end
        exp_q.push_back(d);
        acc_cyc = cyc;
        $display("push %04h at cycle %0d", d, cyc);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 20000) begin
            @(posedge DCK);
            #2;
            n++;
        end
        if (n >= 20000) fail_now("drain_timeout");
    endtask

    task automatic do_reset();
        @(posedge DCK);
        #2;
        rst = 1'b1;
        pix_valid = 1'b0;
        @(posedge DCK);
        @(posedge DCK);
        #2;
        rst = 1'b0;
        exp_q.delete();
        rise_q.delete();
    endtask

    always @(negedge DCK) begin
        if (rst) begin
            den_prev  = 1'b0;
            mon_first = 1'b1;
            bitpos    = 0;
            out_cnt   = 0;
            low_len   = 0;
        end else begin
            if (DEN) begin
                if (!den_prev) begin
                    started++;
                    rise_q.push_back(cyc);
                    if (!mon_first) begin
                        check("gap_len", (low_len >= ((out_cnt % 512 == 0) ? 4 : 2)), 1);
                        if (out_cnt % 512 == 0) frame_gap_len = low_len;
                    end
                    check("pix_idx", 32'(pix_idx), out_cnt % 512);
                    bitpos   = 0;
                    mon_word = '0;
                end
                if (bitpos < 16) mon_word[bitpos] = DAI;
                bitpos++;
            end else begin
                if (den_prev) begin
                    check("bit_count", bitpos, 16);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $error("FAIL word_unexpected: observed %04h expected none", mon_word);
                    end else begin
                        $display("word %04h idx %0d", mon_word, out_cnt % 512);
                        check("word", mon_word, exp_q.pop_front());
                    end
                    out_cnt++;
                    low_len   = 0;
                    mon_first = 1'b0;
                end
                low_len++;
            end
            if (frame_done) begin
                fd_cycles++;
                check("frame_done_pos", (out_cnt > 0 && out_cnt % 512 == 0 && !DEN), 1);
            end
            den_prev = DEN;
        end
    end

    initial begin
        int n;
        int base;
        int high_cnt;
        rst = 1'b1;
        pix_valid = 1'b0;
        pix_data = '0;
        repeat (3) @(posedge DCK);
        #2;
        check("rst_den", DEN, 0);
        check("rst_dai", DAI, 0);
        check("rst_idx", 32'(pix_idx), 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", pix_ready, 1);
        rst = 1'b0;

        // single word: latency and index step
        push_word(16'hA5C3);
        pix_valid = 1'b0;
        wait_drain();
        if (rise_q.size() == 0) fail_now("single_rise");
        else check("latency", rise_q[0] - acc_cyc, 1);
        check("idx_after_single", 32'(pix_idx), 1);

        // burst of 6 with valid held high
        rise_q.delete();
        for (int i = 0; i < 6; i++) begin
            push_word(16'h1000 + 16'(i));
            if (i == 4) check("ready_full", pix_ready, 0);
        end
        pix_valid = 1'b0;
        wait_drain();
        check("burst_rises", rise_q.size(), 6);
        for (int i = 1; i < 6 && i < rise_q.size(); i++)
            check("burst_period", rise_q[i] - rise_q[i-1], 18);

        // starvation mid-frame
        push_word(16'h3C3C);
        push_word(16'hC3C3);
        pix_valid = 1'b0;
        wait_drain();
        high_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge DCK);
            #2;
            if (DEN) high_cnt++;
        end
        check("starve_den_low", high_cnt, 0);
        push_word(16'h0001);
        push_word(16'h8000);
        pix_valid = 1'b0;
        wait_drain();
        check("idx_after_starve", 32'(pix_idx), out_cnt % 512);

        // push and pop on the same edge with three entries queued
        push_word(16'h5555);
        pix_valid = 1'b0;
        n = 0;
        while (!DEN && n < 100) begin @(posedge DCK); #2; n++; end
        if (n >= 100) fail_now("wait_den");
        push_word(16'h6666);
        push_word(16'h7777);
        push_word(16'h8888);
        pix_valid = 1'b0;
        check("count_three", 32'(dut.u_fifo.count), 3);
        n = 0;
        while (dut.state_reg != ST_IDLE && n < 100) begin @(posedge DCK); #2; n++; end
        if (n >= 100) fail_now("wait_idle");
        check("ready_before_pushpop", pix_ready, 1);
        pix_valid = 1'b1;
        pix_data  = 16'h9999;
        @(posedge DCK);
        #2;
        exp_q.push_back(16'h9999);
        pix_valid = 1'b0;
        check("count_pushpop", 32'(dut.u_fifo.count), 3);
        check("ready_pushpop", pix_ready, 1);
        wait_drain();

        // reset at bit 7 of word 3 with two words queued
        base = started;
        for (int i = 0; i < 6; i++) push_word(16'h2000 + 16'(i));
        pix_valid = 1'b0;
        n = 0;
        while (!(started == base + 4 && bitpos == 7) && n < 2000) begin @(posedge DCK); #2; n++; end
        if (n >= 2000) fail_now("wait_bit7");
        rst = 1'b1;
        @(posedge DCK);
        #2;
        check("midrst_den", DEN, 0);
        check("midrst_ready", pix_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_idx", 32'(pix_idx), 0);
        check("midrst_frame_done", frame_done, 0);
        rst = 1'b0;
        exp_q.delete();
        push_word(16'h1234);
        pix_valid = 1'b0;
        wait_drain();
        check("idx_after_midrst", 32'(pix_idx), 1);

        // full frame plus one word
        do_reset();
        fd_cycles = 0;
        frame_gap_len = 0;
        for (int i = 0; i < 513; i++) push_word(16'(i));
        pix_valid = 1'b0;
        wait_drain();
        check("frame_done_cycles", fd_cycles, 1);
        check("frame_gap_len", frame_gap_len, 4);
        check("idx_after_frame", 32'(pix_idx), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
